// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for cpu_mem_arbiter: FSM state encoding, watchdog width and
// a small helper deciding whether a CPU step needs a data access.
package cpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Watchdog counter width; TIMEOUT must fit in this many bits.
  localparam int WDOG_W = 16;

  // A step needs a data phase for a load, a store, or both.
  function automatic logic needs_data(input logic rd, input logic [3:0] wr);
    return rd | (|wr);
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_fetch_buf.sv
// Single-entry fetch buffer (tag, word, valid). Filled on every fetch ack,
// invalidated by a data write to the buffered word or by reset.
// Only compiled when ARB_FETCH_BUF_EN is defined, matching its only user.
`ifdef ARB_FETCH_BUF_EN
module cpu_mem_arbiter_fetch_buf (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        fill_i,
  input  logic [29:0] fill_tag_i,
  input  logic [31:0] fill_word_i,
  input  logic        inv_i,
  input  logic [29:0] inv_tag_i,
  input  logic [29:0] look_tag_i,
  output logic        hit_o,
  output logic [31:0] word_o
);

  logic [29:0] tag_q;
  logic [31:0] word_q;
  logic        vld_q;

  // Entry register: fill wins; fill and invalidate never coincide (different FSM states).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else if (fill_i) begin
      tag_q  <= fill_tag_i;
      word_q <= fill_word_i;
      vld_q  <= 1'b1;
    end else if (inv_i && (inv_tag_i == tag_q)) begin
      vld_q  <= 1'b0;
    end
  end

  assign hit_o  = vld_q && (look_tag_i == tag_q);
  assign word_o = word_q;

endmodule
`endif

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: sequences one instruction fetch and an optional data access
// per CPU step over a single memory bus, then pulses both CPU valids for one cycle.
// Optional single-entry fetch buffer enabled with `define ARB_FETCH_BUF_EN.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter bit RST_FETCH = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_addr_i,
  output logic [31:0] o_data_i,
  output logic        o_valid_i,
  input  logic [31:0] i_addr_d,
  input  logic [31:0] i_data_wr_d,
  input  logic [3:0]  i_wr_d,
  input  logic        i_rd_d,
  output logic [31:0] o_data_rd_d,
  output logic        o_valid_d,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_we,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_bus_err
);

  arb_state_e        state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [31:0]       data_i_q, data_i_d;
  logic [31:0]       data_rd_q, data_rd_d;
  logic              bus_err_q, bus_err_d;
  logic              timeout;
  logic              done;
  logic              buf_hit;
  logic [31:0]       buf_word;

  // Watchdog expiry: this cycle counts as a completion with the bus request dropped.
  assign timeout = (TIMEOUT != 0) && (wdog_q == WDOG_W'(TIMEOUT));

`ifdef ARB_FETCH_BUF_EN
  logic buf_fill, buf_inv;
  assign buf_fill = (state_q == ST_FETCH) && !buf_hit && !timeout && i_mem_ack;
  assign buf_inv  = (state_q == ST_DATA) && (i_mem_ack || timeout) && (|i_wr_d);

  cpu_mem_arbiter_fetch_buf u_fetch_buf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .fill_i      (buf_fill),
    .fill_tag_i  (i_addr_i[31:2]),
    .fill_word_i (i_mem_rdata),
    .inv_i       (buf_inv),
    .inv_tag_i   (i_addr_d[31:2]),
    .look_tag_i  (i_addr_i[31:2]),
    .hit_o       (buf_hit),
    .word_o      (buf_word)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_word = '0;
`endif

  // Next-state, bus outputs and result capture for the step sequencer.
  always_comb begin
    state_d     = state_q;
    wdog_d      = '0;
    data_i_d    = data_i_q;
    data_rd_d   = data_rd_q;
    bus_err_d   = bus_err_q;
    done        = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_we    = '0;
    case (state_q)
      ST_IDLE: begin
        if (RST_FETCH || i_start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        o_mem_addr = i_addr_i;
        o_mem_req  = !buf_hit && !timeout;
        if (buf_hit) begin
          data_i_d = buf_word;
          done     = 1'b1;
        end else if (timeout) begin
          data_i_d  = '0;
          bus_err_d = 1'b1;
          done      = 1'b1;
        end else if (i_mem_ack) begin
          data_i_d = i_mem_rdata;
          done     = 1'b1;
        end else if (TIMEOUT != 0) begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
        if (done) state_d = needs_data(i_rd_d, i_wr_d) ? ST_DATA : ST_DONE;
      end
      ST_DATA: begin
        o_mem_addr  = i_addr_d;
        o_mem_wdata = i_data_wr_d;
        o_mem_we    = i_wr_d;
        o_mem_req   = !timeout;
        if (timeout) begin
          if (i_rd_d) data_rd_d = '0;
          bus_err_d = 1'b1;
          done      = 1'b1;
        end else if (i_mem_ack) begin
          if (i_rd_d) data_rd_d = i_mem_rdata;
          done = 1'b1;
        end else if (TIMEOUT != 0) begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
        if (done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; synchronous reset discards any in-flight access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      wdog_q    <= '0;
      data_i_q  <= '0;
      data_rd_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      data_i_q  <= data_i_d;
      data_rd_q <= data_rd_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign o_valid_i   = (state_q == ST_DONE);
  assign o_valid_d   = (state_q == ST_DONE);
  assign o_data_i    = data_i_q;
  assign o_data_rd_d = data_rd_q;
  assign o_bus_err   = bus_err_q;

endmodule
